hdmi_pack_codec: RTL and testbench

- Bundles one video pixel stream into a single packed bus, and splits a packed bus back into its fields.
- Pack side: registers sync, data-enable and RGB, and generates active-region pixel coordinates (x, y) internally.
- Unpack side: pure combinational field slicing.
- Used at every video-pipeline stage boundary so that filters pass one bus instead of nine signals.

---
 rtl/hdmi_pack_codec.sv | 98 +++++++++
 tb/tb_hdmi_pack_codec.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hdmi_pack_codec.sv
// Packs one video pixel stream (sync, de, RGB plus generated x/y coordinates) into a single bus
// with one cycle of latency, and slices a packed bus back into its individual fields.
module hdmi_pack_codec #(
   parameter  int H_ACT     = 1280,
   parameter  int V_ACT     = 720,
   localparam int XW        = $clog2(H_ACT),
   localparam int YW        = $clog2(V_ACT),
   localparam int PACK_SIZE = 3*8 + 4 + XW + YW
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 hsync,
   input  logic                 vsync,
   input  logic                 de,
   input  logic [7:0]           r,
   input  logic [7:0]           g,
   input  logic [7:0]           b,
   output logic [PACK_SIZE-1:0] o_pack,
   input  logic [PACK_SIZE-1:0] i_pack,
   output logic                 u_clk,
   output logic                 u_hsync,
   output logic                 u_vsync,
   output logic                 u_de,
   output logic [7:0]           u_r,
   output logic [7:0]           u_g,
   output logic [7:0]           u_b,
   output logic [XW-1:0]        u_x,
   output logic [YW-1:0]        u_y
);

   localparam logic [XW-1:0] X_MAX = XW'(H_ACT - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(V_ACT - 1);

   logic          r_hsync;
   logic          r_vsync;
   logic          r_de;
   logic [7:0]    r_r;
   logic [7:0]    r_g;
   logic [7:0]    r_b;
   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic [XW-1:0] r_xCnt;
   logic [YW-1:0] r_yCnt;
   logic          w_deFall;
   logic          w_vsRise;

   // The registered de/vsync fields double as the edge-detect history.
   assign w_deFall = r_de & ~de;
   assign w_vsRise = vsync & ~r_vsync;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_hsync <= 1'b0;
         r_vsync <= 1'b0;
         r_de    <= 1'b0;
         r_r     <= '0;
         r_g     <= '0;
         r_b     <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_xCnt  <= '0;
         r_yCnt  <= '0;
      end else begin
         r_hsync <= hsync;
         r_vsync <= vsync;
         r_de    <= de;
         r_r     <= r;
         r_g     <= g;
         r_b     <= b;
         r_x     <= de ? r_xCnt : '0;
         r_y     <= r_yCnt;
         if (de) begin
            if (r_xCnt != X_MAX) r_xCnt <= r_xCnt + 1'b1;
         end else begin
            r_xCnt <= '0;
         end
         // A frame start wins over a line end arriving in the same cycle.
         if (w_vsRise) begin
            r_yCnt <= '0;
         end else if (w_deFall && (r_yCnt != Y_MAX)) begin
            r_yCnt <= r_yCnt + 1'b1;
         end
      end
   end

   assign o_pack = {clk, r_hsync, r_vsync, r_de, r_r, r_g, r_b, r_x, r_y};

   assign u_clk   = i_pack[PACK_SIZE-1];
   assign u_hsync = i_pack[PACK_SIZE-2];
   assign u_vsync = i_pack[PACK_SIZE-3];
   assign u_de    = i_pack[PACK_SIZE-4];
   assign u_r     = i_pack[PACK_SIZE-5  -: 8];
   assign u_g     = i_pack[PACK_SIZE-13 -: 8];
   assign u_b     = i_pack[PACK_SIZE-21 -: 8];
   assign u_x     = i_pack[YW +: XW];
   assign u_y     = i_pack[YW-1:0];

endmodule

// File: tb/tb_hdmi_pack_codec.sv
// Directed and randomized bench for hdmi_pack_codec: a line/frame counting model predicts every
// packed word, and the packed bus is looped back into the unpacker.
module tb_hdmi_pack_codec;

   localparam int H_ACT = 1280;
   localparam int V_ACT = 720;
   localparam int XW    = 11;
   localparam int YW    = 10;
   localparam int PS    = 49;

   logic          clk = 1'b0;
   logic          rstn;
   logic          hsync, vsync, de;
   logic [7:0]    r, g, b;
   logic [PS-1:0] o_pack;
   logic [PS-1:0] i_pack;
   logic          u_clk, u_hsync, u_vsync, u_de;
   logic [7:0]    u_r, u_g, u_b;
   logic [XW-1:0] u_x;
   logic [YW-1:0] u_y;

   int errors = 0;
   int checks = 0;

   // Model state: length of the current de run, line index in frame, previous de/vsync.
   int   mRun  = 0;
   int   mLine = 0;
   bit   mPrevDe = 1'b0;
   bit   mPrevVs = 1'b0;
   logic [47:0] expWord;
   bit   expYValid;

   hdmi_pack_codec dut (
      .clk     (clk),
      .rstn    (rstn),
      .hsync   (hsync),
      .vsync   (vsync),
      .de      (de),
      .r       (r),
      .g       (g),
      .b       (b),
      .o_pack  (o_pack),
      .i_pack  (i_pack),
      .u_clk   (u_clk),
      .u_hsync (u_hsync),
      .u_vsync (u_vsync),
      .u_de    (u_de),
      .u_r     (u_r),
      .u_g     (u_g),
      .u_b     (u_b),
      .u_x     (u_x),
      .u_y     (u_y)
   );

   always #5 clk = ~clk;

   assign i_pack = o_pack;

   task automatic checkOutput();
      @(posedge clk);
      #1;
      checks++;
      assert (o_pack[PS-1] === 1'b1) else begin
         errors++; $error("FAIL clk_bit_high got=%b exp=1", o_pack[PS-1]);
      end
      checks++;
      assert (o_pack[47:10] === expWord[47:10]) else begin
         errors++; $error("FAIL pack_fields got=%h exp=%h", o_pack[47:10], expWord[47:10]);
      end
      checks++;
      assert ({u_hsync, u_vsync, u_de, u_r, u_g, u_b, u_x} === expWord[47:10]) else begin
         errors++; $error("FAIL unpack_fields got=%h exp=%h",
                          {u_hsync, u_vsync, u_de, u_r, u_g, u_b, u_x}, expWord[47:10]);
      end
      if (expYValid) begin
         checks++;
         assert (o_pack[9:0] === expWord[9:0]) else begin
            errors++; $error("FAIL pack_y got=%0d exp=%0d", o_pack[9:0], expWord[9:0]);
         end
         checks++;
         assert (u_y === expWord[9:0]) else begin
            errors++; $error("FAIL unpack_y got=%0d exp=%0d", u_y, expWord[9:0]);
         end
      end
      #5;
      checks++;
      assert ({o_pack[PS-1], u_clk} === 2'b00) else begin
         errors++; $error("FAIL clk_bit_low got=%b exp=00", {o_pack[PS-1], u_clk});
      end
   endtask

   // Drives one pixel, predicts the packed word it must produce, then checks it.
   task automatic applyStimulus(input bit iRstn, input bit iHs, input bit iVs, input bit iDe,
                                input logic [7:0] iR, input logic [7:0] iG, input logic [7:0] iB);
      int ex;
      rstn = iRstn; hsync = iHs; vsync = iVs; de = iDe; r = iR; g = iG; b = iB;
      if (!iRstn) begin
         expWord   = '0;
         expYValid = 1'b1;
         mRun = 0; mLine = 0; mPrevDe = 1'b0; mPrevVs = 1'b0;
      end else begin
         ex        = iDe ? ((mRun < H_ACT-1) ? mRun : H_ACT-1) : 0;
         expWord   = {iHs, iVs, iDe, iR, iG, iB, XW'(ex), YW'(mLine)};
         expYValid = iDe;
         mRun      = iDe ? mRun + 1 : 0;
         if (iVs && !mPrevVs) mLine = 0;
         else if (!iDe && mPrevDe && mLine < V_ACT-1) mLine = mLine + 1;
         mPrevDe = iDe;
         mPrevVs = iVs;
      end
      checkOutput();
   endtask

   task automatic blank(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 8'h10, 8'h20, 8'h30);
   endtask

   task automatic line(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 1, 8'(i), 8'(i * 3), 8'(i * 7));
   endtask

   task automatic vsPulse();
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, 8'h00, 8'h00, 8'h00);
   endtask

   initial begin
      rstn = 1'b0; hsync = 1'b0; vsync = 1'b0; de = 1'b0; r = '0; g = '0; b = '0;

      $display("[TB] reset with random inputs");
      for (int i = 0; i < 3; i++)
         applyStimulus(0, 1'($urandom), 1'($urandom), 1'($urandom),
                       8'($urandom), 8'($urandom), 8'($urandom));

      $display("[TB] full active line");
      for (int i = 0; i < H_ACT; i++) applyStimulus(1, 0, 0, 1, 8'hAA, 8'h55, 8'h0F);
      blank(10);

      $display("[TB] line counting across vsync");
      vsPulse();
      blank(5);
      for (int l = 0; l < 3; l++) begin
         line(40);
         blank(12);
      end
      vsPulse();
      blank(4);
      line(40);
      blank(8);

      $display("[TB] x saturation");
      line(1300);
      blank(6);

      $display("[TB] random loopback lines");
      for (int l = 0; l < 2; l++) begin
         for (int i = 0; i < 30; i++)
            applyStimulus(1, 1'($urandom), 1'($urandom), 0,
                          8'($urandom), 8'($urandom), 8'($urandom));
         for (int i = 0; i < 200; i++)
            applyStimulus(1, 1'($urandom), 1'($urandom_range(0, 7) == 0), 1,
                          8'($urandom), 8'($urandom), 8'($urandom));
      end
      blank(6);

      $display("[TB] mid-line reset");
      vsPulse();
      blank(3);
      for (int l = 0; l < 5; l++) begin
         line(20);
         blank(5);
      end
      line(600);
      applyStimulus(0, 0, 0, 1, 8'hEE, 8'hDD, 8'hCC);
      line(50);
      blank(7);
      line(30);
      blank(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
